// File: rtl/switch_pio_irq_pkg.sv
// Shared constants for the switch/button PIO: register word addresses and edge-capture modes.
package switch_pio_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RAW  = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/switch_pio_irq_if.sv
// Avalon-MM slave bus for the switch PIO: word address, select, active-low write, 32-bit data.
interface switch_pio_irq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);

endinterface

// File: rtl/switch_pio_irq_debounce.sv
// One debounced input bit: a new synchronised value is accepted only after it has
// differed from the accepted value for DEBOUNCE_CYCLES consecutive cycles.
module switch_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_q;

    // Run-length counter of disagreement; any return to the accepted value restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
            r_q   <= 1'b0;
        end else if (d == r_q) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_q   <= d;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1'b1);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/switch_pio_irq.sv
// Switch/key input port: synchroniser, per-bit debounce, edge capture with W1C,
// interrupt mask and a level IRQ, behind a 1-cycle-latency Avalon-MM slave.
module switch_pio_irq
    import switch_pio_pkg::*;
#(
    parameter int WIDTH           = 10,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int EDGE_TYPE       = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    switch_pio_irq_if.slave      bus,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] r_stable_d;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clear;
    logic [WIDTH-1:0] r_edge;
    logic [WIDTH-1:0] r_mask;
    logic [31:0]      w_rd_mux;
    logic [31:0]      r_readdata;
    logic             w_wr;
    logic             w_unused_wdata;

    assign w_wr           = bus.chipselect & ~bus.write_n;
    assign w_sync         = r_sync[SYNC_STAGES-1];
    assign w_unused_wdata = ^bus.writedata;

    // Metastability chain from the asynchronous pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_port};
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_db
        switch_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (w_sync[i]),
            .q       (w_stable[i])
        );
    end

    // Edge selection and the W1C clear vector for the capture register.
    always_comb begin
        w_edge  = '0;
        w_clear = '0;
        case (EDGE_TYPE)
            EDGE_RISE: w_edge = w_stable & ~r_stable_d;
            EDGE_FALL: w_edge = ~w_stable & r_stable_d;
            default:   w_edge = w_stable ^ r_stable_d;
        endcase
        if (w_wr && (bus.address == ADDR_EDGE)) begin
            w_clear = bus.writedata[WIDTH-1:0];
        end else begin
            w_clear = '0;
        end
    end

    // Edge history, capture (a new edge beats a same-cycle clear) and mask.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable_d <= '0;
            r_edge     <= '0;
            r_mask     <= '0;
        end else begin
            r_stable_d <= w_stable;
            r_edge     <= (r_edge & ~w_clear) | w_edge;
            if (w_wr && (bus.address == ADDR_MASK)) begin
                r_mask <= bus.writedata[WIDTH-1:0];
            end else begin
                r_mask <= r_mask;
            end
        end
    end

    // Read mux; the address is sampled every cycle regardless of chipselect.
    always_comb begin
        w_rd_mux = 32'h0;
        case (bus.address)
            ADDR_DATA: w_rd_mux = 32'(w_stable);
            ADDR_RAW:  w_rd_mux = 32'(w_sync);
            ADDR_MASK: w_rd_mux = 32'(r_mask);
            default:   w_rd_mux = 32'(r_edge);
        endcase
    end

    // Registered read data gives the single cycle of read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'h0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edge & r_mask);

endmodule

// File: tb/tb_switch_pio_irq.sv
// Bench for switch_pio_irq: three instances (rise/fall/any) share one stimulus and are
// compared each cycle against a window-based model, plus directed literal reads.
module tb_switch_pio_irq;
    import switch_pio_pkg::*;

    localparam int W  = 10;
    localparam int SS = 2;
    localparam int DC = 4;

    logic         clk;
    logic         reset_n;
    logic [W-1:0] in_port;
    logic [1:0]   tb_addr;
    logic         tb_cs;
    logic         tb_wn;
    logic [31:0]  tb_wd;
    logic         irq0, irq1, irq2;
    logic [31:0]  rd0, rd1, rd2;

    int n_tests = 0;
    int n_fail  = 0;

    switch_pio_irq_if bus0 ();
    switch_pio_irq_if bus1 ();
    switch_pio_irq_if bus2 ();

    assign bus0.address = tb_addr; assign bus0.chipselect = tb_cs;
    assign bus0.write_n = tb_wn;   assign bus0.writedata  = tb_wd;
    assign bus1.address = tb_addr; assign bus1.chipselect = tb_cs;
    assign bus1.write_n = tb_wn;   assign bus1.writedata  = tb_wd;
    assign bus2.address = tb_addr; assign bus2.chipselect = tb_cs;
    assign bus2.write_n = tb_wn;   assign bus2.writedata  = tb_wd;
    assign rd0 = bus0.readdata;
    assign rd1 = bus1.readdata;
    assign rd2 = bus2.readdata;

    switch_pio_irq #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0)) u_rise (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));
    switch_pio_irq #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)) u_fall (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq1));
    switch_pio_irq #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset_n(reset_n), .bus(bus2), .in_port(in_port), .irq(irq2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: the synchroniser is a delay line, debounce is "the last DC samples all disagree".
    logic [W-1:0] m_sync_q[$];
    logic [W-1:0] m_win[$];
    logic [W-1:0] m_stable, m_stable_d;
    logic [W-1:0] m_ec[3];
    logic [W-1:0] m_mask[3];
    logic [31:0]  m_rd[3];
    int           m_coll;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_sync_q.delete();
        m_win.delete();
        for (int i = 0; i < SS; i++) m_sync_q.push_back('0);
        for (int i = 0; i < DC; i++) m_win.push_back('0);
        m_stable   = '0;
        m_stable_d = '0;
        for (int k = 0; k < 3; k++) begin
            m_ec[k]   = '0;
            m_mask[k] = '0;
            m_rd[k]   = 32'h0;
        end
    endtask

    task automatic model_step();
        logic [W-1:0] s_old, nstab, rise, fall, det, clr;
        logic         wr;
        bit           all_diff;
        s_old = m_sync_q[0];
        wr    = tb_cs && !tb_wn;
        for (int k = 0; k < 3; k++) begin
            case (tb_addr)
                2'd0:    m_rd[k] = {22'h0, m_stable};
                2'd1:    m_rd[k] = {22'h0, s_old};
                2'd2:    m_rd[k] = {22'h0, m_mask[k]};
                default: m_rd[k] = {22'h0, m_ec[k]};
            endcase
        end
        m_win.push_back(s_old);
        void'(m_win.pop_front());
        nstab = m_stable;
        for (int b = 0; b < W; b++) begin
            all_diff = 1'b1;
            foreach (m_win[i]) if (m_win[i][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) nstab[b] = s_old[b];
        end
        rise = m_stable & ~m_stable_d;
        fall = ~m_stable & m_stable_d;
        clr  = (wr && tb_addr == 2'd3) ? tb_wd[W-1:0] : '0;
        for (int k = 0; k < 3; k++) begin
            det = (k == 0) ? rise : (k == 1) ? fall : (rise | fall);
            if (k == 0 && (det & clr) != '0) m_coll++;
            m_ec[k] = (m_ec[k] & ~clr) | det;
            if (wr && tb_addr == 2'd2) m_mask[k] = tb_wd[W-1:0];
        end
        m_stable_d = m_stable;
        m_stable   = nstab;
        m_sync_q.push_back(in_port);
        void'(m_sync_q.pop_front());
    endtask

    initial begin
        m_coll = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else          model_step();
        end
    end

    // Every-cycle comparison of all three instances against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (reset_n === 1'b1) begin
                check("rd_rise",  rd0, m_rd[0]);
                check("rd_fall",  rd1, m_rd[1]);
                check("rd_any",   rd2, m_rd[2]);
                check("irq_rise", {31'h0, irq0}, {31'h0, |(m_ec[0] & m_mask[0])});
                check("irq_fall", {31'h0, irq1}, {31'h0, |(m_ec[1] & m_mask[1])});
                check("irq_any",  {31'h0, irq2}, {31'h0, |(m_ec[2] & m_mask[2])});
            end
        end
    end

    task automatic rd_chk(input logic [1:0] a, input logic [W-1:0] e0, input logic [W-1:0] e1,
                          input logic [W-1:0] e2, input string name);
        tb_addr = a;
        tb_cs   = 1'b1;
        tb_wn   = 1'b1;
        @(negedge clk);
        check({name, "_rise"},  rd0,     {22'h0, e0});
        check({name, "_fall"},  rd1,     {22'h0, e1});
        check({name, "_any"},   rd2,     {22'h0, e2});
        check({name, "_model"}, m_rd[0], {22'h0, e0});
        tb_cs = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        tb_addr = a;
        tb_cs   = 1'b1;
        tb_wn   = 1'b0;
        tb_wd   = d;
        @(negedge clk);
        tb_cs = 1'b0;
        tb_wn = 1'b1;
        tb_wd = 32'h0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        in_port = 10'h3FF;
        tb_addr = 2'd0;
        tb_cs   = 1'b0;
        tb_wn   = 1'b1;
        tb_wd   = 32'h0;
        idle(3);
        reset_n = 1'b1;

        // Reset readback, then RAW after the synchroniser, then pins debounced high.
        rd_chk(ADDR_DATA, 10'h000, 10'h000, 10'h000, "rst_data");
        rd_chk(ADDR_RAW,  10'h000, 10'h000, 10'h000, "rst_raw");
        rd_chk(ADDR_MASK, 10'h000, 10'h000, 10'h000, "rst_mask");
        rd_chk(ADDR_EDGE, 10'h000, 10'h000, 10'h000, "rst_edge");
        check("rst_irq", {31'h0, irq0 | irq1 | irq2}, 32'h0);
        rd_chk(ADDR_RAW,  10'h3FF, 10'h3FF, 10'h3FF, "raw_high");
        idle(6);
        rd_chk(ADDR_DATA, 10'h3FF, 10'h3FF, 10'h3FF, "data_high");
        rd_chk(ADDR_EDGE, 10'h3FF, 10'h000, 10'h3FF, "init_edge");
        in_port = 10'h000;
        idle(10);
        rd_chk(ADDR_EDGE, 10'h3FF, 10'h3FF, 10'h3FF, "init_fall");
        bus_write(ADDR_EDGE, 32'h0000_03FF);
        rd_chk(ADDR_EDGE, 10'h000, 10'h000, 10'h000, "init_clear");

        // Glitch of three cycles on bit0 is rejected.
        in_port = 10'h001;
        idle(3);
        in_port = 10'h000;
        idle(8);
        rd_chk(ADDR_DATA, 10'h000, 10'h000, 10'h000, "glitch_data");
        rd_chk(ADDR_EDGE, 10'h000, 10'h000, 10'h000, "glitch_edge");

        // Accepted rising edge on bit3; irq only once unmasked.
        in_port = 10'h008;
        idle(8);
        rd_chk(ADDR_DATA, 10'h008, 10'h008, 10'h008, "rise_data");
        rd_chk(ADDR_EDGE, 10'h008, 10'h000, 10'h008, "rise_edge");
        check("masked_irq", {31'h0, irq0}, 32'h0);
        bus_write(ADDR_MASK, 32'h0000_0008);
        check("unmask_irq", {31'h0, irq0}, 32'h1);

        // New bit3 rising edge detected on the same edge as a W1C of bit3: set wins.
        in_port = 10'h000;
        idle(8);
        in_port = 10'h008;
        idle(6);
        bus_write(ADDR_EDGE, 32'h0000_0008);
        check("collision_seen", m_coll, 32'd1);
        rd_chk(ADDR_EDGE, 10'h008, 10'h000, 10'h008, "collide_edge");
        check("irq_held", {31'h0, irq0}, 32'h1);
        bus_write(ADDR_EDGE, 32'h0000_0008);
        check("irq_cleared", {31'h0, irq0}, 32'h0);
        rd_chk(ADDR_EDGE, 10'h000, 10'h000, 10'h000, "w1c_edge");

        // bit5 up then down: per-mode capture, each transition cleared on its own.
        in_port = 10'h028;
        idle(8);
        rd_chk(ADDR_EDGE, 10'h020, 10'h000, 10'h020, "b5_rise");
        bus_write(ADDR_EDGE, 32'h0000_0020);
        rd_chk(ADDR_EDGE, 10'h000, 10'h000, 10'h000, "b5_clr1");
        in_port = 10'h008;
        idle(8);
        rd_chk(ADDR_EDGE, 10'h000, 10'h020, 10'h020, "b5_fall");
        bus_write(ADDR_EDGE, 32'h0000_0020);
        rd_chk(ADDR_EDGE, 10'h000, 10'h000, 10'h000, "b5_clr2");

        // Read-only registers ignore writes; mask keeps only WIDTH bits.
        bus_write(ADDR_DATA, 32'hFFFF_FFFF);
        bus_write(ADDR_RAW,  32'hFFFF_FFFF);
        rd_chk(ADDR_DATA, 10'h008, 10'h008, 10'h008, "ro_data");
        rd_chk(ADDR_RAW,  10'h008, 10'h008, 10'h008, "ro_raw");
        bus_write(ADDR_MASK, 32'hFFFF_FFFF);
        rd_chk(ADDR_MASK, 10'h3FF, 10'h3FF, 10'h3FF, "mask_width");

        // Asynchronous reset in the middle of a debounce clears everything.
        in_port = 10'h3FF;
        idle(3);
        #2 reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        rd_chk(ADDR_DATA, 10'h000, 10'h000, 10'h000, "mid_rst_data");
        rd_chk(ADDR_MASK, 10'h000, 10'h000, 10'h000, "mid_rst_mask");
        rd_chk(ADDR_EDGE, 10'h000, 10'h000, 10'h000, "mid_rst_edge");
        check("mid_rst_irq", {31'h0, irq0 | irq1 | irq2}, 32'h0);
        idle(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_pio_irq.md
Name: switch_pio_irq

Overview:
Parametrised Avalon-MM slave input port for board switches and buttons. It is the successor to the team's plain switch PIO and adds:
- an input synchroniser
- a per-bit debouncer
- edge capture under a selectable edge mode
- an interrupt mask driving a level IRQ to the Nios II

It sits between the FPGA switch/key pins and the system interconnect.

Parameters:
WIDTH, 10, number of input bits (1..32).
SYNC_STAGES, 2, flip-flop stages in the metastability synchroniser (>=2).
DEBOUNCE_CYCLES, 500000, cycles a synchronised bit must stay at a new value before it is accepted (>=1; 10 ms at 50 MHz).
EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 any.

Ports:
clk  in  1  system clock; single clock domain.
reset_n  in  1  asynchronous active-low reset.
address  in  2  Avalon word address.
chipselect  in  1  Avalon slave select.
write_n  in  1  active-low write strobe, qualified by chipselect.
writedata  in  32  write data.
readdata  out  32  registered read data.
in_port  in  WIDTH  asynchronous switch/key pins.
irq  out  1  level interrupt, active high.

Behaviour:
- Reset (async, reset_n=0): readdata, sync chain, debounced value, debounce counters, irq_mask, edge_capture all go to 0, so irq=0.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync[WIDTH-1:0].
- Debounce (per bit), with stable = accepted value:
  - sync==stable: counter cleared to 0.
  - sync!=stable: counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1 and sync still differs, stable<=sync and the counter clears.
  - Any return of sync to stable before then clears the counter, so the glitch is rejected.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Latency from pin to stable is SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- Edge detect on stable, using stable_d (stable delayed one cycle):
  - rise = stable & ~stable_d
  - fall = ~stable & stable_d
  - EDGE_TYPE selects rise, fall or rise|fall.
  - A detected edge sets the corresponding edge_capture bit.
  - Because stable resets to 0, a pin already high at reset produces one rising edge once debounced. This is intended; firmware clears edge_capture at init.
- Register map (word address):
  - 0 DATA, RO: stable, zero-extended to 32 bits.
  - 1 RAW, RO: sync, zero-extended.
  - 2 IRQ_MASK, RW: bits [WIDTH-1:0].
  - 3 EDGE_CAPTURE, RW1C: writing 1 clears that bit; writing 0 leaves it.
- Write: when chipselect && !write_n, the register at address updates on that clock edge.
  - Writes to addresses 0 and 1 are ignored.
  - writedata bits >= WIDTH are ignored.
- Read:
  - Every cycle, readdata <= mux(address), whatever chipselect is.
  - Latency is 1 cycle (readLatency=1); there are no wait states.
  - Unused upper bits read 0.
- Simultaneous edge set and W1C clear on the same bit in the same cycle: set wins, so the bit stays 1.
- irq = |(edge_capture & irq_mask). It is built only from registers and stays asserted until firmware clears the capture or mask bit.
- Mask writes do not affect edge_capture. Edges are captured even while masked, so unmasking later raises irq immediately.
- Reset mid-debounce or mid-edge: all state clears at once, with no partial update.

Decomposition:
- Package switch_pio_pkg holds:
  - address constants: ADDR_DATA=0, ADDR_RAW=1, ADDR_MASK=2, ADDR_EDGE=3
  - edge type constants: EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2
- Sub-module switch_debounce_bit (params DEBOUNCE_CYCLES; ports clk, reset_n, d, q) holds the per-bit counter and accepted value. It is instantiated WIDTH times by a generate loop.
- The synchroniser, edge logic and register file live in the top level.

Test Plan:
1. Reset and readback: reset_n low while in_port=10'h3FF, then release. Reading addresses 0..3 gives 0 at cycle 1. RAW reads 0x3FF after SYNC_STAGES+1 cycles. irq=0.
2. Glitch rejection (DEBOUNCE_CYCLES=4): bit0 high for 3 cycles then low. DATA stays 0 and edge_capture stays 0.
3. Accepted rising edge (DEBOUNCE_CYCLES=4, EDGE_TYPE=0): bit3 held high. DATA=0x008 after 2+4 cycles and edge_capture=0x008. irq rises only after IRQ_MASK is written with 0x008.
4. W1C with collision: edge_capture=0x008.
   - Write 0x008 to address 3 in the same cycle a new bit3 edge is detected: the bit stays set.
   - Repeat the write with no edge: the bit clears and irq falls on the next cycle.
5. Falling/any modes: EDGE_TYPE=1 captures only the 1->0 transition of bit5. EDGE_TYPE=2 captures both transitions, and each is cleared individually.
6. RO protection and width: write 0xFFFFFFFF to addresses 0 and 1, then to address 2. DATA/RAW are unchanged and IRQ_MASK reads 0x3FF, with upper bits 0.
